bus_dev_port: RTL
=================

// Module: bus_dev_port
// PURPOSE
//  Device-side port adapter for the bs_gnrtr_n_rbtr bus: one instance per device (drvrs of them).
//  TX FIFO buffers device packets and presents them to the bus via pndng/D_pop/pop.
//  RX FIFO captures bus deliveries (push/D_push) and hands them to the device with valid/ready.
//  Lets the bus run unmodified against real devices in place of the bench driver model.
// PARAMETERS
//  pckg_sz    16      packet width; [pckg_sz-1 -: 8] = destination ID
//  depth      8       entries per FIFO, power of 2, >= 2
//  id         0       this device's ID (8 bits), stamped into tx_src_id
//  broadcast  8'hFF   destination ID meaning "all devices"
// PORTS
//  clk           in   1        system clock, all logic on rising edge
//  reset         in   1        asynchronous, active-low reset
//  dev_tx_valid  in   1        device offers a packet
//  dev_tx_data   in   pckg_sz  packet from device (dest ID in top 8 bits)
//  dev_tx_ready  out  1        TX FIFO can accept (= !tx_full)
//  pndng         out  1        to bus: TX FIFO not empty
//  D_pop         out  pckg_sz  to bus: TX FIFO head (show-ahead)
//  pop           in   1        from bus: consume TX head
//  push          in   1        from bus: deliver D_push
//  D_push        in   pckg_sz  packet delivered by bus
//  dev_rx_valid  out  1        RX FIFO not empty
//  dev_rx_data   out  pckg_sz  RX head (show-ahead)
//  dev_rx_ready  in   1        device consumes RX head
//  rx_bcast      out  1        RX head dest field == broadcast
//  err_pop_empty out  1        sticky: pop seen while pndng=0
//  rx_drop_cnt   out  16       RX overflow drop count (see CONFIGURATION)
// BEHAVIOUR
//  Reset (reset=0, async): FIFO pointers/counts 0; pndng=0, dev_tx_ready=1, dev_rx_valid=0,
//   rx_bcast=0, err_pop_empty=0, rx_drop_cnt=0; D_pop/dev_rx_data = 0. Reset mid-transfer
//   discards all FIFO contents; no partial packet survives.
//  TX write: dev_tx_valid & dev_tx_ready at edge -> entry stored; pndng=1 the next cycle.
//  TX read: pop & pndng at edge -> head advances; D_pop shows next entry the next cycle.
//   Latency device->pndng: 1 cycle. pop with pndng=0: ignored, err_pop_empty set (sticky).
//  TX full: dev_tx_ready=0 from registered count; a write attempted while full is ignored even
//   if pop occurs the same cycle (ready decides, not same-cycle space).
//  RX write: push at edge -> D_push stored if count<depth, OR count==depth and
//   dev_rx_valid&dev_rx_ready same cycle (simultaneous read frees slot). Otherwise dropped.
//   The bus never stalls; dropped packets are lost.
//  RX read: dev_rx_valid & dev_rx_ready -> head advances; dev_rx_valid next cycle = count_next>0.
//  Simultaneous write+read on either FIFO: count unchanged, both pointers advance.
//  Pointers are log2(depth) bits, wrap modulo depth; count is log2(depth)+1 bits, 0..depth.
//  rx_bcast combinational from dev_rx_data[pckg_sz-1 -: 8]; 0 when dev_rx_valid=0.
//  No state machine beyond FIFO bookkeeping; each FIFO state = {EMPTY, PARTIAL, FULL} by count.
// CONFIGURATION
//  BUS_DEV_DROP_CNT_EN defined: rx_drop_cnt increments on each dropped RX push, saturates at
//   16'hFFFF, cleared only by reset.
//  Not defined: counter logic absent; rx_drop_cnt tied to 16'h0; drop behaviour unchanged.
// STRUCTURE
//  Package bus_pkg: ID_W=8, BCAST_ID=8'hFF, function dest_of(pkt) extracting dest field,
//   typedef of FIFO count type parameterised via localparam in user module.
//  Sub-module bus_fifo_sync (depth, width; wr_en, wr_data, rd_en, rd_data, full, empty,
//   count, wr_drop): instantiated twice (TX, RX); RX instance enables full+read write-through.
// TESTING
//  1 Reset then write 3 pkts 16'h0112,16'h0234,16'h0356 -> pndng=1 one cycle after first,
//    D_pop=16'h0112; three pops yield 0112,0234,0356 in order; pndng=0 after third.
//  2 Write 8 pkts without pop -> dev_tx_ready=0; 9th write with pop same cycle ignored;
//    after pop, dev_tx_ready=1, D_pop=2nd packet.
//  3 pop while empty -> err_pop_empty=1 and stays 1; pointers unchanged (pndng stays 0).
//  4 Fill RX (8 pushes, dev_rx_ready=0), push 16'hFFAA -> dropped, rx_drop_cnt=1 (macro on,
//    0 off); push with dev_rx_ready=1 same cycle -> accepted, count stays 8.
//  5 push 16'hFF55 into empty RX -> dev_rx_valid=1 next cycle, rx_bcast=1, data=16'hFF55.
//  6 Assert reset=0 asynchronously mid-burst with both FIFOs half full -> all outputs at
//    reset values before next clk edge; after release FIFOs empty, traffic resumes normally.

Source files
------------

// File: rtl/bus_pkg.sv
// bus_pkg: shared constants, types and helpers for the bus device port.
package bus_pkg;

    localparam int          ID_W     = 8;
    localparam logic [7:0]  BCAST_ID = 8'hFF;
    localparam int          PKT_MAX  = 64;

    // Occupancy classes of a FIFO, derived purely from its count.
    typedef enum logic [1:0] {
        FIFO_EMPTY,
        FIFO_PARTIAL,
        FIFO_FULL
    } fifo_state_e;

    typedef logic [15:0] drop_cnt_t;

    // Destination ID lives in the top ID_W bits of a w-bit packet.
    function automatic logic [ID_W-1:0] dest_of(input logic [PKT_MAX-1:0] pkt, input int w);
        return ID_W'(pkt >> (w - ID_W));
    endfunction

endpackage

// File: rtl/bus_fifo_sync.sv
// bus_fifo_sync: synchronous show-ahead FIFO; WR_THRU lets a write land on a full FIFO when a read frees a slot the same cycle.
module bus_fifo_sync
    import bus_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int WIDTH   = 16,
    parameter bit WR_THRU = 1'b0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     wr_drop
);

    localparam int AW = $clog2(DEPTH);
    typedef logic [AW:0] cnt_t;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    cnt_t             cnt;
    fifo_state_e      state;
    logic             wr;
    logic             rd;

    // Classify occupancy and qualify the requests against it.
    always_comb begin
        state   = (cnt == '0) ? FIFO_EMPTY : ((cnt == cnt_t'(DEPTH)) ? FIFO_FULL : FIFO_PARTIAL);
        empty   = (state == FIFO_EMPTY);
        full    = (state == FIFO_FULL);
        rd      = rd_en & ~empty;
        wr      = wr_en & (~full | (WR_THRU & rd));
        wr_drop = wr_en & ~wr;
        rd_data = empty ? '0 : mem[rd_ptr];
        count   = cnt;
    end

    // Pointer and count bookkeeping; reset discards every stored entry.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            wr_ptr <= wr ? wr_ptr + AW'(1) : wr_ptr;
            rd_ptr <= rd ? rd_ptr + AW'(1) : rd_ptr;
            cnt    <= cnt + cnt_t'(wr) - cnt_t'(rd);
        end
    end

    // Storage array; contents are only visible through the pointers, so no reset needed.
    always_ff @(posedge clk) begin
        if (wr)
            mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/bus_dev_port.sv
// bus_dev_port: device-side TX/RX FIFO adapter for the bs_gnrtr_n_rbtr bus.
// Optional feature: define BUS_DEV_DROP_CNT_EN to enable the saturating RX drop counter.
module bus_dev_port
    import bus_pkg::*;
#(
    parameter int         pckg_sz   = 16,
    parameter int         depth     = 8,
    parameter logic [7:0] id        = 8'h00,
    parameter logic [7:0] broadcast = BCAST_ID
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                dev_tx_valid,
    input  logic [pckg_sz-1:0]  dev_tx_data,
    output logic                dev_tx_ready,
    output logic                pndng,
    output logic [pckg_sz-1:0]  D_pop,
    input  logic                pop,
    input  logic                push,
    input  logic [pckg_sz-1:0]  D_push,
    output logic                dev_rx_valid,
    output logic [pckg_sz-1:0]  dev_rx_data,
    input  logic                dev_rx_ready,
    output logic                rx_bcast,
    output logic                err_pop_empty,
    output logic [15:0]         rx_drop_cnt,
    output logic [ID_W-1:0]     tx_src_id
);

    localparam int CW = $clog2(depth) + 1;

    logic          tx_full;
    logic          tx_empty;
    logic          tx_drop;
    logic [CW-1:0] tx_count;
    logic          rx_full;
    logic          rx_empty;
    logic          rx_drop;
    logic [CW-1:0] rx_count;
    logic          unused_sink;

    // TX: a write while full is refused even if the bus pops the same cycle.
    bus_fifo_sync #(
        .DEPTH   (depth),
        .WIDTH   (pckg_sz),
        .WR_THRU (1'b0)
    ) u_tx (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (dev_tx_valid),
        .wr_data (dev_tx_data),
        .rd_en   (pop),
        .rd_data (D_pop),
        .full    (tx_full),
        .empty   (tx_empty),
        .count   (tx_count),
        .wr_drop (tx_drop)
    );

    // RX: the bus never stalls, so a full FIFO still accepts when the device reads the same cycle.
    bus_fifo_sync #(
        .DEPTH   (depth),
        .WIDTH   (pckg_sz),
        .WR_THRU (1'b1)
    ) u_rx (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (push),
        .wr_data (D_push),
        .rd_en   (dev_rx_ready),
        .rd_data (dev_rx_data),
        .full    (rx_full),
        .empty   (rx_empty),
        .count   (rx_count),
        .wr_drop (rx_drop)
    );

    // Handshake and status outputs derived from FIFO occupancy.
    always_comb begin
        dev_tx_ready = ~tx_full;
        pndng        = ~tx_empty;
        dev_rx_valid = ~rx_empty;
        rx_bcast     = dev_rx_valid & (dest_of(PKT_MAX'(dev_rx_data), pckg_sz) == broadcast);
        tx_src_id    = id;
        unused_sink  = ^{tx_drop, rx_drop, tx_count, rx_count, rx_full};
    end

    // Sticky flag: the bus popped while nothing was pending.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            err_pop_empty <= 1'b0;
        else if (pop && tx_empty)
            err_pop_empty <= 1'b1;
    end

`ifdef BUS_DEV_DROP_CNT_EN
    drop_cnt_t drop_q;

    // Count RX pushes lost to overflow, saturating instead of wrapping.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            drop_q <= '0;
        else if (rx_drop && drop_q != 16'hFFFF)
            drop_q <= drop_q + 16'd1;
    end

    assign rx_drop_cnt = drop_q;
`else
    assign rx_drop_cnt = 16'h0;
`endif

endmodule
